// File: rtl/alu_pkg.sv
// Shared opcode and controller state encodings for the ALU issue controller.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_EQL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 2**AW x DW register file: two combinational read ports, one synchronous write port.
module alu_regfile #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] regs [2**AW];

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: loads go straight into the register file, ALU ops take
// one ISSUE cycle on the external ALU and then wait in RESP for the consumer.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_ld,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_rd,
    output state_t        fsm_state
);

    // Handshakes: a command moves on a rising edge with cmd_valid && cmd_ready,
    // a response moves on a rising edge with rsp_valid && rsp_ready; neither
    // side may withdraw or change its payload while waiting.

    state_t        state;
    logic [AW-1:0] rd_q;
    logic          cmd_fire;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata_a;
    logic [DW-1:0] rf_rdata_b;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign fsm_state = state;

    // The only writes are an accepted load in IDLE or the ALU write-back that
    // closes ISSUE, so operands latched at accept stay valid through ISSUE.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = cmd_rd;
        rf_wdata = cmd_imm;
        if (state == ST_ISSUE) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = alu_result;
        end else if (cmd_fire && cmd_ld) begin
            rf_we = 1'b1;
        end
    end

    alu_regfile #(.DW(DW), .AW(AW)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (cmd_rs1),
        .raddr_b (cmd_rs2),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire && !cmd_ld) begin
                        state     <= ST_ISSUE;
                        cmd_ready <= 1'b0;
                        rd_q      <= cmd_rd;
                        alu_a     <= rf_rdata_a;
                        alu_b     <= rf_rdata_b;
                        alu_op    <= cmd_op;
                    end
                end
                ST_ISSUE: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_result;
                    rsp_rd    <= rd_q;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_op    <= '0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
